trap_controller: RTL
====================

// Module: trap_controller
// PURPOSE
//   Machine-mode interrupt arbiter, directly downstream of the memory-mapped timer.
//   Consumes the timer's level interrupt, a software interrupt bit and an async external line.
//   Applies enables and fixed priority, then raises a trap request to the core with a handshake.
//   Latches cause/EPC on acceptance, supplies the trap vector, and releases on mret.
//   Registers sit on the same 32-bit data bus as the timer, directly above it in the address map.
// PARAMETERS
//   BASE_ADDR    32'hFFFF0010  address of first register; 6 word registers, 0x00..0x14
//   RESET_VEC    32'h00000100  reset value of VEC
// PORTS
//   clk           in   1   system clock, rising edge
//   rst           in   1   asynchronous, active-high reset
//   address       in   32  bus address
//   write_data    in   32  bus write data
//   write_enable  in   1   bus write strobe; write occurs at posedge when address hits
//   read_data     out  32  combinational read of addressed register; 0 when no hit
//   hit           out  1   address within BASE_ADDR..BASE_ADDR+0x14, word aligned
//   timer_irq     in   1   level interrupt from timer (mtime >= mtimecmp)
//   ext_irq       in   1   asynchronous external interrupt, level
//   irq_req       out  1   trap request to core; 1 iff state==REQ
//   irq_ack       in   1   core accepts trap at instruction boundary; sampled only when irq_req=1
//   pc_in         in   32  PC to save; sampled with irq_ack
//   mret          in   1   core executes mret; honoured only in SERVICE
//   trap_vector   out  32  handler entry address
//   epc_out       out  32  current EPC; core's return target on mret
// BEHAVIOUR
//   Register map (offset): 0x00 IE[2:0] RW {ext,sw,tmr}; 0x04 IP[2:0] RO; 0x08 MSIP[0] RW;
//     0x0C CAUSE RO; 0x10 EPC RW; 0x14 VEC RW, bits[1:0] forced 0. Unused bits read 0.
//   Reset: IE=0, MSIP=0, CAUSE=0, EPC=0, VEC=RESET_VEC, sync flops=0, state=IDLE, irq_req=0.
//   ext_irq passes a 2-flop synchronizer: IP[2] follows ext_irq 2 cycles later. IP[0]=timer_irq,
//     IP[1]=MSIP, both combinational.
//   pend = IP & IE. Priority ext > sw > tmr. Cause: ext 0x8000000B, sw 0x80000003, tmr 0x80000007.
//   FSM (registered, one transition per posedge):
//     IDLE   : pend!=0 -> REQ, latch candidate cause (cand) of highest pending source.
//     REQ    : irq_ack=1 -> SERVICE; CAUSE<=cand, EPC<=pc_in. Ack wins over withdrawal.
//              irq_ack=0 & pend==0 -> IDLE (request withdrawn, CAUSE unchanged).
//              irq_ack=0 & pend!=0 -> stay; cand re-evaluated each cycle (higher priority preempts).
//     SERVICE: all new requests masked (no nesting); mret=1 -> IDLE. Earliest re-request is
//              the cycle after IDLE, so a still-high timer_irq re-traps after 2 cycles.
//   irq_ack outside REQ and mret outside SERVICE ignored; no state change.
//   Bus write to CAUSE ignored. Bus write to EPC in the same cycle as the accepting ack:
//     the hardware latch wins. Bus writes are allowed in any state and do not change it.
//   Clearing IE or MSIP while in REQ: withdrawal takes effect on the next edge per REQ rules.
//   Reset asserted mid-operation: immediate return to reset values; irq_req drops asynchronously.
// CONFIGURATION
//   TRAP_CTRL_VECTORED_EN defined  : trap_vector = VEC + 4*CAUSE[4:0] (e.g. tmr -> VEC+0x1C).
//   TRAP_CTRL_VECTORED_EN undefined: trap_vector = VEC for every cause (direct mode).
//   CAUSE, EPC and the register map are identical in both builds.
// TESTING
//   T1 reset: rst=1 -> irq_req=0, read VEC=0x100, IE=0, CAUSE=0, EPC=0, trap_vector=0x100.
//   T2 timer: IE=0x1, timer_irq=1 -> irq_req=1 next edge; ack with pc_in=0x40 -> CAUSE=0x80000007,
//      EPC=0x40, irq_req=0; mret -> IDLE; timer_irq still 1 -> irq_req=1 two cycles after mret.
//   T3 priority: IE=0x7, timer_irq=1 and MSIP=1 together, then ext_irq=1 before ack -> CAUSE
//      at ack =0x8000000B; pulsing irq_ack/mret while SERVICE/IDLE has no effect.
//   T4 withdrawal: IE=0x1, timer_irq 1 -> irq_req=1; drop timer_irq, no ack -> IDLE next edge,
//      CAUSE unchanged; repeat with ack on the drop cycle -> SERVICE, CAUSE=0x80000007.
//   T5 vectored: VEC=0x200, MSIP trap -> trap_vector=0x20C when TRAP_CTRL_VECTORED_EN defined,
//      0x200 when undefined; bus write 0xFFFF to CAUSE reads back unchanged.
//   T6 async reset in SERVICE: rst pulse mid-cycle -> irq_req=0, IE=0, EPC=0 before next edge.

Source files
------------

// File: rtl/trap_controller.sv
// Machine-mode trap controller: enable/priority arbitration, request/ack handshake, CAUSE/EPC/VEC registers.
// Optional build macro TRAP_CTRL_VECTORED_EN selects vectored trap_vector (VEC + 4*CAUSE[4:0]).
module trap_controller #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0010,
    parameter logic [31:0] RESET_VEC = 32'h00000100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    output logic [31:0] read_data,
    output logic        hit,
    input  logic        timer_irq,
    input  logic        ext_irq,
    output logic        irq_req,
    input  logic        irq_ack,
    input  logic [31:0] pc_in,
    input  logic        mret,
    output logic [31:0] trap_vector,
    output logic [31:0] epc_out
);

    localparam logic [31:0] CAUSE_EXT = 32'h8000000B;
    localparam logic [31:0] CAUSE_SW  = 32'h80000003;
    localparam logic [31:0] CAUSE_TMR = 32'h80000007;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cand_q, cand_d;
    logic [2:0]  ie_q;
    logic        msip_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;
    logic [31:0] vec_q;
    logic [1:0]  ext_sync_q;

    logic [31:0] offset_s;
    logic        hit_s;
    logic        wr_s;
    logic [2:0]  ip_s;
    logic [2:0]  pend_s;
    logic [31:0] best_cause_s;
    logic        accept_s;

    // Addresses below BASE_ADDR wrap to a large offset and therefore miss.
    assign offset_s = address - BASE_ADDR;
    assign hit_s    = (offset_s <= 32'h00000014) && (offset_s[1:0] == 2'b00);
    assign wr_s     = write_enable && hit_s;
    assign hit      = hit_s;

    assign ip_s     = {ext_sync_q[1], msip_q, timer_irq};
    assign pend_s   = ip_s & ie_q;
    assign accept_s = (state_q == ST_REQ) && irq_ack;
    assign irq_req  = (state_q == ST_REQ);
    assign epc_out  = epc_q;

`ifdef TRAP_CTRL_VECTORED_EN
    assign trap_vector = vec_q + {25'd0, cause_q[4:0], 2'b00};
`else
    assign trap_vector = vec_q;
`endif

    // Fixed priority selection ext > sw > tmr.
    always_comb begin
        best_cause_s = 32'd0;
        if (pend_s[2]) begin
            best_cause_s = CAUSE_EXT;
        end else if (pend_s[1]) begin
            best_cause_s = CAUSE_SW;
        end else if (pend_s[0]) begin
            best_cause_s = CAUSE_TMR;
        end else begin
            best_cause_s = 32'd0;
        end
    end

    // Next-state and candidate-cause logic; ack takes precedence over withdrawal.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_s != 3'b000) begin
                    state_d = ST_REQ;
                    cand_d  = best_cause_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_d = ST_SERVICE;
                end else if (pend_s == 3'b000) begin
                    state_d = ST_IDLE;
                end else begin
                    cand_d  = best_cause_s;
                end
            end
            ST_SERVICE: begin
                if (mret) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and candidate cause registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cand_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
        end
    end

    // Bus-writable registers, trap latches and ext_irq synchronizer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q       <= 3'b000;
            msip_q     <= 1'b0;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            vec_q      <= RESET_VEC;
            ext_sync_q <= 2'b00;
        end else begin
            ext_sync_q <= {ext_sync_q[0], ext_irq};
            if (wr_s) begin
                case (offset_s[4:2])
                    3'd0:    ie_q   <= write_data[2:0];
                    3'd2:    msip_q <= write_data[0];
                    3'd4:    if (!accept_s) epc_q <= write_data;
                    3'd5:    vec_q  <= {write_data[31:2], 2'b00};
                    default: ;
                endcase
            end
            // The hardware latch overrides a coincident bus write to EPC.
            if (accept_s) begin
                cause_q <= cand_q;
                epc_q   <= pc_in;
            end
        end
    end

    // Combinational register read; unmapped or missed addresses return 0.
    always_comb begin
        read_data = 32'd0;
        if (hit_s) begin
            case (offset_s[4:2])
                3'd0:    read_data = {29'd0, ie_q};
                3'd1:    read_data = {29'd0, ip_s};
                3'd2:    read_data = {31'd0, msip_q};
                3'd3:    read_data = cause_q;
                3'd4:    read_data = epc_q;
                3'd5:    read_data = vec_q;
                default: read_data = 32'd0;
            endcase
        end else begin
            read_data = 32'd0;
        end
    end

endmodule
